// File: rtl/fft_pkg.sv
// fft_pkg: shared state encodings and address helper for the FFT output-side control.
package fft_pkg;
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_RUN   = 4'b0010;
    localparam logic [3:0] ST_DRAIN = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    // Mirrors the low n bits of v; bits at and above n come out zero.
    function automatic logic [15:0] bit_rev(input logic [15:0] v, input logic [4:0] n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i < int'(n)) r[i] = v[int'(n) - 1 - i];
        return r;
    endfunction
endpackage

// File: rtl/fft_out_ctrl_if.sv
// fft_out_ctrl_if: result-buffer read port plus AXI-stream output of the FFT output controller.
interface fft_out_ctrl_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
);
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [2*DATA_WIDTH-1:0] m_axi_data;
    logic                    m_axi_valid;
    logic                    m_axi_last;
    logic                    m_axi_ready;

    modport master (output rd_en, rd_addr, m_axi_data, m_axi_valid, m_axi_last,
                    input  rd_data, m_axi_ready);
    modport slave  (input  rd_en, rd_addr, m_axi_data, m_axi_valid, m_axi_last,
                    output rd_data, m_axi_ready);
endinterface

// File: rtl/fft_skid_fifo.sv
// fft_skid_fifo: 2-entry fall-through FIFO; a push into an empty FIFO is visible at the head at once.
module fft_skid_fifo #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp, rp, take, store, deq;

    assign valid = count != 2'd0 || push;
    assign dout  = count != 2'd0 ? mem[rp] : push ? din : '0;
    assign take  = pop && valid;
    // A word popped in the same cycle it arrives at an empty FIFO bypasses storage.
    assign store = push && !(count == 2'd0 && take);
    assign deq   = take && count != 2'd0;

    always_ff @(posedge clk)
        if (store) mem[wp] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (store) wp <= ~wp;
            if (deq) rp <= ~rp;
            count <= count + 2'(store) - 2'(deq);
        end
endmodule

// File: rtl/fft_out_ctrl.sv
// fft_out_ctrl: reads the FFT result buffer (optionally bit-reversed) and streams it out on AXI-stream.
module fft_out_ctrl
    import fft_pkg::*;
#(
    parameter int    LEN_WIDTH   = 16,
    parameter int    DATA_WIDTH  = 18,
    parameter int    ADDR_WIDTH  = 10,
    parameter string BIT_REVERSE = "ON"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LEN_WIDTH-1:0] dft_length,
    input  logic [3:0]           fft_lev_limit,
    input  logic                 fft_cdone,
    output logic                 fft_odone,
    output logic                 busy,
    fft_out_ctrl_if.master       bus
);
    logic [3:0]              state, state_nx;
    logic [ADDR_WIDTH-1:0]   rcnt, cnt_max;
    logic [4:0]              nbits, lev_p1;
    logic [1:0]              count, credit;
    logic [2*DATA_WIDTH:0]   head;
    logic                    rd_en_d, last_d, is_last, last_hs;

    assign lev_p1   = {1'b0, fft_lev_limit} + 5'd1;
    assign is_last  = rcnt == cnt_max;
    // Reserve a FIFO slot for every word already stored or still coming back from the buffer.
    assign credit   = 2'd2 - count - {1'b0, rd_en_d};
    assign bus.rd_en = state == ST_RUN && credit != 2'd0;
    assign bus.rd_addr = BIT_REVERSE == "ON" ? ADDR_WIDTH'(bit_rev(16'(rcnt), nbits)) : rcnt;
    assign last_hs  = bus.m_axi_valid && bus.m_axi_ready && bus.m_axi_last;
    assign fft_odone = state == ST_DONE;
    assign busy     = state != ST_IDLE;
    assign bus.m_axi_last = head[2*DATA_WIDTH];
    assign bus.m_axi_data = head[2*DATA_WIDTH-1:0];

    always_comb
        state_nx = state == ST_IDLE  ? (fft_cdone ? ST_RUN : ST_IDLE) :
                   state == ST_RUN   ? (bus.rd_en && is_last ? ST_DRAIN : ST_RUN) :
                   state == ST_DRAIN ? (last_hs ? ST_DONE : ST_DRAIN) : ST_IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= ST_IDLE;
            rcnt    <= '0;
            cnt_max <= '0;
            nbits   <= '0;
            rd_en_d <= 1'b0;
            last_d  <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_en_d <= bus.rd_en;
            last_d  <= bus.rd_en && is_last;
            if (bus.rd_en) rcnt <= rcnt + ADDR_WIDTH'(1);
            if (state == ST_IDLE && fft_cdone) begin
                rcnt    <= '0;
                cnt_max <= ADDR_WIDTH'(dft_length);
                nbits   <= lev_p1 > 5'(ADDR_WIDTH) ? 5'(ADDR_WIDTH) : lev_p1;
            end
        end

    fft_skid_fifo #(.W(2*DATA_WIDTH+1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_en_d),
        .din   ({last_d, bus.rd_data}),
        .pop   (bus.m_axi_ready),
        .dout  (head),
        .valid (bus.m_axi_valid),
        .count (count)
    );
endmodule

// File: tb/tb_fft_out_ctrl.sv
// tb_fft_out_ctrl: scoreboard bench for fft_out_ctrl, bit-reversed and linear instances side by side.
module tb_fft_out_ctrl;
    logic        clk, rst_n, cdone, ready, sel;
    logic [15:0] dft_length;
    logic [3:0]  fft_lev_limit;
    logic        odone_on, odone_off, busy_on, busy_off;
    int          n_vec = 0, n_err = 0;
    int          cyc = 0, accepted = 0, outst = 0, odone_cnt = 0, odone_due = -1, last_hs = 0;
    int          mode = 0, base = 0, stall_n = 0;
    logic [36:0] exp_data [$];
    logic [9:0]  exp_addr [$];
    logic [36:0] prev_word, e;
    logic        prev_stall = 1'b0;

    fft_out_ctrl_if #(.DATA_WIDTH(18), .ADDR_WIDTH(10)) b ();
    fft_out_ctrl_if #(.DATA_WIDTH(18), .ADDR_WIDTH(10)) bo ();

    fft_out_ctrl #(.BIT_REVERSE("ON")) dut (
        .clk(clk), .rst_n(rst_n), .dft_length(dft_length), .fft_lev_limit(fft_lev_limit),
        .fft_cdone(cdone & ~sel), .fft_odone(odone_on), .busy(busy_on), .bus(b));
    fft_out_ctrl #(.BIT_REVERSE("OFF")) dut_off (
        .clk(clk), .rst_n(rst_n), .dft_length(dft_length), .fft_lev_limit(fft_lev_limit),
        .fft_cdone(cdone & sel), .fft_odone(odone_off), .busy(busy_off), .bus(bo));

    logic        o_rd_en, o_valid, o_last, o_odone, o_busy;
    logic [9:0]  o_rd_addr;
    logic [35:0] o_data;
    assign o_rd_en   = sel ? bo.rd_en : b.rd_en;
    assign o_rd_addr = sel ? bo.rd_addr : b.rd_addr;
    assign o_valid   = sel ? bo.m_axi_valid : b.m_axi_valid;
    assign o_last    = sel ? bo.m_axi_last : b.m_axi_last;
    assign o_data    = sel ? bo.m_axi_data : b.m_axi_data;
    assign o_odone   = sel ? odone_off : odone_on;
    assign o_busy    = sel ? busy_off : busy_on;
    assign b.m_axi_ready  = ready;
    assign bo.m_axi_ready = ready;

    function automatic logic [35:0] word(input logic [9:0] a);
        return {8'h5A, a, 8'hA5, a};
    endfunction

    function automatic int brev(input int v, input int n);
        int r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Result buffer model: one-cycle read latency, contents derived from the address.
    always @(posedge clk) begin
        if (b.rd_en) b.rd_data <= word(b.rd_addr);
        if (bo.rd_en) bo.rd_data <= word(bo.rd_addr);
    end

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 1) ready = !ready;
            else if (mode == 2 && accepted > base && stall_n < 20) begin
                ready = 1'b0;
                stall_n++;
            end else ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_addr.delete();
            exp_data.delete();
            outst = 0;
            odone_due = -1;
            prev_stall = 1'b0;
        end else begin
            if (o_rd_en) begin
                chk("credit", outst <= 1, 1);
                if (exp_addr.size() == 0) chk("extra_read", o_rd_en, 0);
                else chk("rd_addr", o_rd_addr, exp_addr.pop_front());
            end
            if (prev_stall) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", {o_last, o_data}, prev_word);
            end
            if (o_valid && ready) begin
                accepted++;
                last_hs = cyc;
                if (exp_data.size() == 0) chk("extra_beat", o_valid, 0);
                else begin
                    e = exp_data.pop_front();
                    chk("data", o_data, e[35:0]);
                    chk("last", o_last, e[36]);
                end
                if (o_last) odone_due = cyc + 1;
            end
            if (o_odone || cyc == odone_due) begin
                chk("odone", o_odone, cyc == odone_due);
                if (o_odone) odone_cnt++;
            end
            outst = outst + int'(o_rd_en) - int'(o_valid && ready);
            prev_stall = o_valid && !ready;
            prev_word = {o_last, o_data};
        end
    end

    task automatic run(input bit s, input int len, input int lev, input int m,
                       input int glitch, input int abort);
        int a, n0, a0, t0;
        sel = s;
        mode = m;
        dft_length = 16'(len);
        fft_lev_limit = 4'(lev);
        for (int i = 0; i <= len; i++) begin
            a = s ? i : brev(i, lev + 1 > 10 ? 10 : lev + 1);
            exp_addr.push_back(10'(a));
            exp_data.push_back({i == len, word(10'(a))});
        end
        n0 = odone_cnt;
        a0 = accepted;
        base = accepted;
        @(posedge clk); #1 cdone = 1'b1;
        @(posedge clk); #1 cdone = 1'b0;
        dft_length = 16'($urandom);
        fft_lev_limit = 4'($urandom);
        chk("lat_rd_en", o_rd_en, 1);
        chk("lat_busy", o_busy, 1);
        chk("lat_valid_early", o_valid, 0);
        @(posedge clk); #1 chk("lat_valid", o_valid, 1);
        t0 = cyc + 1;
        if (glitch > 0) begin
            repeat (glitch) @(posedge clk);
            #1 cdone = 1'b1;
            @(posedge clk); #1 cdone = 1'b0;
        end
        if (abort > 0) begin
            for (int k = 0; k < 4000 && accepted - a0 < abort; k++) @(posedge clk);
            chk("abort_reached", accepted - a0 >= abort, 1);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_valid", o_valid, 0);
            chk("rst_rd_en", o_rd_en, 0);
            chk("rst_rd_addr", o_rd_addr, 0);
            chk("rst_data", {o_last, o_data}, 0);
            chk("rst_busy", o_busy, 0);
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (6) @(posedge clk);
            chk("abort_no_odone", odone_cnt - n0, 0);
            return;
        end
        for (int k = 0; k < 6000 && odone_cnt == n0; k++) @(posedge clk);
        chk("odone_seen", odone_cnt - n0, 1);
        #1;
        chk("idle_busy", o_busy, 0);
        chk("beats_drained", exp_data.size(), 0);
        chk("reads_drained", exp_addr.size(), 0);
        if (m == 0) chk("back_to_back", last_hs - t0, len);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cdone = 1'b0;
        sel = 1'b0;
        dft_length = '0;
        fft_lev_limit = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", b.m_axi_valid, 0);
        chk("reset_last", b.m_axi_last, 0);
        chk("reset_data", b.m_axi_data, 0);
        chk("reset_rd_en", b.rd_en, 0);
        chk("reset_rd_addr", b.rd_addr, 0);
        chk("reset_odone", odone_on, 0);
        chk("reset_busy", busy_on, 0);
        chk("reset_off_valid", bo.m_axi_valid, 0);
        chk("reset_off_busy", busy_off, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run(0, 7, 2, 0, 0, 0);
        run(0, 7, 2, 1, 0, 0);
        run(0, 0, 2, 0, 0, 0);
        run(0, 1023, 9, 0, 50, 0);
        run(0, 1023, 9, 0, 0, 100);
        run(0, 1023, 9, 1, 0, 0);
        run(1, 15, 3, 2, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
